aes_pt_unpack: RTL and testbench



---
 rtl/aes_pt_unpack.sv | 94 +++++++++
 tb/tb_aes_pt_unpack.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_pt_unpack.sv
// aes_pt_unpack: plaintext block buffer and 32-bit word serialiser
// behind the AES-256 decryptor, with a ciphertext credit output.
module aes_pt_unpack #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [0:127]  pt,
    input  logic          pt_vld,
    input  logic          ct_accept,
    output logic          ct_allow,
    output logic [0:31]   dout,
    output logic          dout_vld,
    input  logic          dout_rdy,
    output logic          dout_last,
    output logic [CW-1:0] level,
    output logic          overflow
);

    localparam int            AW   = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [0:127]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    widx;
    logic [CW-1:0] out_cnt;
    logic [0:127]  head;
    logic          xfer;
    logic          pop;
    logic          wr_ok;
    logic [CW:0]   credit_sum;

    assign head       = mem[rd_ptr];
    assign dout_vld   = (level != '0);
    assign dout_last  = dout_vld & (widx == 2'd3);
    assign xfer       = dout_vld & dout_rdy;
    assign pop        = xfer & (widx == 2'd3);
    // a block leaving this cycle frees the slot for an arriving one
    assign wr_ok      = pt_vld & ((level < FULL) | pop);
    assign credit_sum = {1'b0, level} + {1'b0, out_cnt};
    assign ct_allow   = credit_sum < {1'b0, FULL};

    always_comb begin
        dout = '0;
        if (dout_vld) begin
            unique case (widx)
                2'd0: dout = head[0:31];
                2'd1: dout = head[32:63];
                2'd2: dout = head[64:95];
                2'd3: dout = head[96:127];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= pt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            widx     <= '0;
            level    <= '0;
            out_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pt_vld & !wr_ok)
                overflow <= 1'b1;
            if (xfer)
                widx <= widx + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);

            unique case ({wr_ok, pop})
                2'b10:   level <= level + CW'(1);
                2'b01:   level <= level - CW'(1);
                default: level <= level;
            endcase

            // blocks in flight inside the decryptor; saturating both ways
            if (ct_accept & !pt_vld & (out_cnt != FULL))
                out_cnt <= out_cnt + CW'(1);
            else if (pt_vld & !ct_accept & (out_cnt != '0))
                out_cnt <= out_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_aes_pt_unpack.sv
// Directed bench for aes_pt_unpack with a word scoreboard
// checked on every falling clock edge.
module tb_aes_pt_unpack;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [0:127]  pt = '0;
    logic          pt_vld = 1'b0;
    logic          ct_accept = 1'b0;
    logic          ct_allow;
    logic [0:31]   dout;
    logic          dout_vld;
    logic          dout_rdy = 1'b0;
    logic          dout_last;
    logic [CW-1:0] level;
    logic          overflow;

    typedef struct packed {
        logic [31:0] w;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;
    int   fails  = 0;
    int   xfers  = 0;

    aes_pt_unpack #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .pt        (pt),
        .pt_vld    (pt_vld),
        .ct_accept (ct_accept),
        .ct_allow  (ct_allow),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .dout_rdy  (dout_rdy),
        .dout_last (dout_last),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [127:0] b, input bit keep);
        exp_t e;
        pt     = b;
        pt_vld = 1'b1;
        if (keep) begin
            for (int i = 0; i < 4; i++) begin
                e.w    = b[127-32*i -: 32];
                e.last = (i == 3);
                sb.push_back(e);
            end
        end
        step();
        pt_vld = 1'b0;
    endtask

    task automatic drain();
        dout_rdy = 1'b1;
        for (int i = 0; i < 200 && level != '0; i++)
            step();
        step();
        dout_rdy = 1'b0;
        chk("drain_level", 32'(level), 0);
        chk("sb_empty", 32'(sb.size()), 0);
    endtask

    function automatic logic [127:0] blk(input logic [31:0] base);
        return {base, base + 32'd1, base + 32'd2, base + 32'd3};
    endfunction

    always @(negedge clk) begin
        if (dout_vld) begin
            total++;
            assert (sb.size() != 0) passed++;
            else begin
                fails++;
                $error("FAIL sb_extra: got %h want no word", dout);
            end
            if (sb.size() != 0) begin
                chk("dout", dout, sb[0].w);
                chk("dout_last", 32'(dout_last), 32'(sb[0].last));
                if (dout_rdy) begin
                    void'(sb.pop_front());
                    xfers++;
                end
            end
        end else begin
            chk("dout_idle", dout, 0);
            chk("last_idle", 32'(dout_last), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        int x0;

        // reset state
        step(2);
        chk("rst_vld", 32'(dout_vld), 0);
        chk("rst_last", 32'(dout_last), 0);
        chk("rst_dout", dout, 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_allow", 32'(ct_allow), 1);
        rst = 1'b1;
        step();

        // single block, full rate
        ct_accept = 1'b1;
        step();
        ct_accept = 1'b0;
        dout_rdy = 1'b1;
        send(128'h00112233_44556677_8899aabb_ccddeeff, 1);
        chk("lat_level", 32'(level), 1);
        chk("lat_word0", dout, 32'h00112233);
        for (int i = 0; i < 4; i++) begin
            chk("lat_vld", 32'(dout_vld), 1);
            step();
        end
        chk("single_level", 32'(level), 0);
        chk("single_vld", 32'(dout_vld), 0);
        dout_rdy = 1'b0;

        // backpressure
        x0 = xfers;
        send(128'h00112233_44556677_8899aabb_ccddeeff, 1);
        for (int i = 0; i < 7; i++) begin
            dout_rdy = pat[i];
            step();
        end
        dout_rdy = 1'b0;
        chk("bp_xfers", 32'(xfers - x0), 4);
        chk("bp_level", 32'(level), 0);

        // credit
        for (int i = 0; i < 4; i++) begin
            ct_accept = 1'b1;
            step();
            ct_accept = 1'b0;
            chk("credit_allow", 32'(ct_allow), (i < 3) ? 1 : 0);
        end
        for (int i = 0; i < 4; i++)
            send(blk(32'hc000_0000 + 32'(i * 16)), 1);
        chk("credit_level", 32'(level), 4);
        chk("credit_out", 32'(dut.out_cnt), 0);
        chk("credit_full", 32'(ct_allow), 0);

        // overflow: fifth block is dropped
        send(blk(32'hdead_0000), 0);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_level", 32'(level), 4);
        step(3);
        chk("ovf_sticky", 32'(overflow), 1);
        dout_rdy = 1'b1;
        step(4);
        dout_rdy = 1'b0;
        chk("drain1_level", 32'(level), 3);
        chk("drain1_allow", 32'(ct_allow), 1);
        drain();
        chk("ovf_after", 32'(overflow), 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("ovf_clr", 32'(overflow), 0);

        // simultaneous pop, write and ct_accept at full
        for (int i = 0; i < 4; i++)
            send(blk(32'hd000_0000 + 32'(i * 16)), 1);
        dout_rdy = 1'b1;
        step(3);
        chk("sim_last", 32'(dout_last), 1);
        ct_accept = 1'b1;
        send(blk(32'he000_0000), 1);
        ct_accept = 1'b0;
        chk("sim_level", 32'(level), 4);
        chk("sim_ovf", 32'(overflow), 0);
        chk("sim_out", 32'(dut.out_cnt), 0);
        drain();

        // continuous stream across pointer wrap
        x0 = xfers;
        dout_rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            send(blk(32'h1000_0000 + 32'(k * 16)), 1);
            step(3);
        end
        drain();
        chk("wrap_xfers", 32'(xfers - x0), 40);

        // async reset mid-block
        for (int i = 0; i < 3; i++)
            send(blk(32'h2000_0000 + 32'(i * 16)), 1);
        ct_accept = 1'b1;
        step();
        ct_accept = 1'b0;
        chk("ar_allow0", 32'(ct_allow), 0);
        chk("ar_out", 32'(dut.out_cnt), 1);
        dout_rdy = 1'b1;
        step(2);
        dout_rdy = 1'b0;
        chk("ar_word2", dout, 32'h2000_0002);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_vld", 32'(dout_vld), 0);
        chk("ar_last", 32'(dout_last), 0);
        chk("ar_level", 32'(level), 0);
        chk("ar_allow", 32'(ct_allow), 1);
        sb.delete();
        step();
        rst = 1'b1;
        step();
        x0 = xfers;
        dout_rdy = 1'b1;
        send(blk(32'h3000_0000), 1);
        chk("ar_first", dout, 32'h3000_0000);
        drain();
        chk("ar_xfers", 32'(xfers - x0), 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
